// File: rtl/sw_event_gen.sv
// Panel push-switch conditioner: 2-flop sync, shared 1 ms tick, per-switch
// debounce / hold / auto-repeat FSM with registered single-cycle event pulses.
module sw_event_gen #(
   parameter int unsigned N_SW     = 3,
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned DEB_MS   = 20,
   parameter int unsigned HOLD_MS  = 600,
   parameter int unsigned REP_MS   = 150
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] i_sw,
   output logic [N_SW-1:0] o_level,
   output logic [N_SW-1:0] o_press,
   output logic [N_SW-1:0] o_long,
   output logic [N_SW-1:0] o_repeat,
   output logic [N_SW-1:0] o_release,
   output logic [N_SW-1:0] o_event
);

   typedef enum logic [2:0] {S_IDLE, S_DEB_P, S_HELD, S_REPEAT, S_DEB_R} state_t;

   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [15:0] DEB_LAST  = 16'(DEB_MS - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);
   localparam logic [15:0] REP_LAST  = 16'(REP_MS - 1);

   logic [N_SW-1:0] sync1_q, sync2_q, p;
   logic [31:0]     presc_q, presc_d;
   logic            tick;
   state_t          state_q [N_SW];
   state_t          state_d [N_SW];
   logic [15:0]     cnt_q   [N_SW];
   logic [15:0]     cnt_d   [N_SW];
   logic [N_SW-1:0] level_d, press_d, long_d, repeat_d, release_d;
   logic [N_SW-1:0] level_q, press_q, long_q, repeat_q, release_q, event_q;

   assign p       = ~sync2_q;
   assign tick    = (presc_q == TICK_LAST);
   assign presc_d = tick ? 32'd0 : presc_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         presc_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         long_q    <= '0;
         repeat_q  <= '0;
         release_q <= '0;
         event_q   <= '0;
         for (int i = 0; i < N_SW; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q   <= i_sw;
         sync2_q   <= sync1_q;
         presc_q   <= presc_d;
         level_q   <= level_d;
         press_q   <= press_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         release_q <= release_d;
         event_q   <= press_d | repeat_d;
         for (int i = 0; i < N_SW; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // A change of p always beats a coincident terminal tick.
   always_comb begin
      for (int i = 0; i < N_SW; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (p[i]) begin
                  state_d[i] = S_DEB_P;
                  cnt_d[i]   = '0;
               end
            end
            S_DEB_P: begin
               if (!p[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end else if (tick) begin
                  if (cnt_q[i] == DEB_LAST) begin
                     state_d[i] = S_HELD;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
            end
            S_HELD: begin
               if (!p[i]) begin
                  state_d[i] = S_DEB_R;
                  cnt_d[i]   = '0;
               end else if (tick) begin
                  if (cnt_q[i] == HOLD_LAST) begin
                     state_d[i] = S_REPEAT;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
            end
            S_REPEAT: begin
               if (!p[i]) begin
                  state_d[i] = S_DEB_R;
                  cnt_d[i]   = '0;
               end else if (tick) begin
                  cnt_d[i] = (cnt_q[i] == REP_LAST) ? 16'd0 : cnt_q[i] + 16'd1;
               end
            end
            S_DEB_R: begin
               if (p[i]) begin
                  state_d[i] = S_HELD;
                  cnt_d[i]   = '0;
               end else if (tick) begin
                  if (cnt_q[i] == DEB_LAST) begin
                     state_d[i] = S_IDLE;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      level_d   = '0;
      press_d   = '0;
      long_d    = '0;
      repeat_d  = '0;
      release_d = '0;
      for (int i = 0; i < N_SW; i++) begin
         level_d[i] = (state_d[i] == S_HELD) || (state_d[i] == S_REPEAT) ||
                      (state_d[i] == S_DEB_R);
         case (state_q[i])
            S_DEB_P:  press_d[i]   = p[i] && tick && (cnt_q[i] == DEB_LAST);
            S_HELD: begin
               long_d[i]   = p[i] && tick && (cnt_q[i] == HOLD_LAST);
               repeat_d[i] = p[i] && tick && (cnt_q[i] == HOLD_LAST);
            end
            S_REPEAT: repeat_d[i]  = p[i] && tick && (cnt_q[i] == REP_LAST);
            S_DEB_R:  release_d[i] = !p[i] && tick && (cnt_q[i] == DEB_LAST);
            default: ;
         endcase
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_long    = long_q;
   assign o_repeat  = repeat_q;
   assign o_release = release_q;
   assign o_event   = event_q;

endmodule

// File: tb/tb_sw_event_gen.sv
// Bench for sw_event_gen: table vectors, directed multi-cycle sequences and
// random switch activity checked every cycle against a behavioural model.
module tb_sw_event_gen;

   localparam int N_SW = 3, TICK_DIV = 4, DEB_MS = 3, HOLD_MS = 5, REP_MS = 2;
   localparam int SEL_LEVEL = 0, SEL_PRESS = 1, SEL_LONG = 2, SEL_REP = 3, SEL_REL = 4, SEL_EVT = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N_SW-1:0] i_sw;
   logic [N_SW-1:0] o_level, o_press, o_long, o_repeat, o_release, o_event;

   sw_event_gen #(.N_SW(N_SW), .TICK_DIV(TICK_DIV), .DEB_MS(DEB_MS),
                  .HOLD_MS(HOLD_MS), .REP_MS(REP_MS)) dut (
      .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
      .o_level(o_level), .o_press(o_press), .o_long(o_long),
      .o_repeat(o_repeat), .o_release(o_release), .o_event(o_event));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic chk_range(input string name, input int v, input int lo, input int hi);
      n_checks++;
      if (v >= lo && v <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
   endtask

   // Behavioural model: debounced level plus an unbounded count of hold ticks.
   logic [N_SW-1:0] dly0, dly1;
   int              edges;
   bit              m_lvl [N_SW];
   bit              m_deb [N_SW];
   int              m_cnt [N_SW];
   int              m_hold[N_SW];
   logic [N_SW-1:0] m_level, m_press, m_long, m_rep, m_rel, m_event;

   always @(posedge clk) begin : mdl
      logic [N_SW-1:0] mp;
      bit              mt;
      if (!rst_n) begin
         dly0 = '1; dly1 = '1; edges = 0;
         m_level = '0; m_press = '0; m_long = '0; m_rep = '0; m_rel = '0; m_event = '0;
         for (int c = 0; c < N_SW; c++) begin
            m_lvl[c] = 0; m_deb[c] = 0; m_cnt[c] = 0; m_hold[c] = 0;
         end
      end else begin
         mp = ~dly0;
         mt = (edges % TICK_DIV) == TICK_DIV - 1;
         edges++;
         dly0 = dly1;
         dly1 = i_sw;
         m_press = '0; m_long = '0; m_rep = '0; m_rel = '0;
         for (int c = 0; c < N_SW; c++) begin
            if (!m_lvl[c]) begin
               if (!m_deb[c]) begin
                  if (mp[c]) begin m_deb[c] = 1; m_cnt[c] = 0; end
               end else if (!mp[c]) begin
                  m_deb[c] = 0;
               end else if (mt) begin
                  m_cnt[c]++;
                  if (m_cnt[c] == DEB_MS) begin
                     m_lvl[c] = 1; m_deb[c] = 0; m_hold[c] = 0; m_press[c] = 1'b1;
                  end
               end
            end else begin
               if (!m_deb[c]) begin
                  if (!mp[c]) begin
                     m_deb[c] = 1; m_cnt[c] = 0;
                  end else if (mt) begin
                     m_hold[c]++;
                     if (m_hold[c] == HOLD_MS) begin
                        m_long[c] = 1'b1; m_rep[c] = 1'b1;
                     end else if (m_hold[c] > HOLD_MS && (m_hold[c] - HOLD_MS) % REP_MS == 0) begin
                        m_rep[c] = 1'b1;
                     end
                  end
               end else if (mp[c]) begin
                  m_deb[c] = 0; m_hold[c] = 0;
               end else if (mt) begin
                  m_cnt[c]++;
                  if (m_cnt[c] == DEB_MS) begin
                     m_lvl[c] = 0; m_deb[c] = 0; m_rel[c] = 1'b1;
                  end
               end
            end
            m_level[c] = m_lvl[c];
         end
         m_event = m_press | m_rep;
      end
      #1;
      chk("model", {14'd0, o_level, o_press, o_long, o_repeat, o_release, o_event},
                   {14'd0, m_level, m_press, m_long, m_rep, m_rel, m_event});
   end

   function automatic logic [N_SW-1:0] outv(input int sel);
      case (sel)
         SEL_LEVEL: return o_level;
         SEL_PRESS: return o_press;
         SEL_LONG:  return o_long;
         SEL_REP:   return o_repeat;
         SEL_REL:   return o_release;
         default:   return o_event;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until the selected output bit is high; lat = cycles taken, -1 on timeout.
   task automatic wait_bit(input int sel, input int ch, input int maxc, output int lat);
      logic [N_SW-1:0] v;
      bit              done;
      lat  = -1;
      done = 0;
      for (int k = 1; k <= maxc && !done; k++) begin
         step();
         v = outv(sel);
         if (v[ch]) begin lat = k; done = 1; end
      end
   endtask

   int cp [N_SW], cl [N_SW], crp [N_SW], cr [N_SW];

   task automatic step_count();
      step();
      for (int c = 0; c < N_SW; c++) begin
         cp[c]  += int'(o_press[c]);
         cl[c]  += int'(o_long[c]);
         crp[c] += int'(o_repeat[c]);
         cr[c]  += int'(o_release[c]);
      end
   endtask

   typedef struct {
      logic [N_SW-1:0] mask;
      int              low;
      int              exp_press;
      int              exp_long;
      int              exp_rel;
      int              exp_rep_min;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int              lat;
      logic [N_SW-1:0] acc;
      int              np, nr, early;
      bit              seen_rel;
      int              dur [N_SW];

      tbl[0] = '{3'b001,  6, 0, 0, 0, 0};
      tbl[1] = '{3'b010,  8, 0, 0, 0, 0};
      tbl[2] = '{3'b100, 14, 1, 0, 1, 0};
      tbl[3] = '{3'b010, 22, 1, 0, 1, 0};
      tbl[4] = '{3'b111, 22, 1, 0, 1, 0};
      tbl[5] = '{3'b101, 45, 1, 1, 1, 1};

      rst_n = 1'b0;
      i_sw  = '1;
      repeat (3) step();
      chk("reset_out", {o_level, o_press, o_long, o_repeat, o_release, o_event}, 0);
      rst_n = 1'b1;
      repeat (10) step();
      chk("idle_out", {o_level, o_press, o_long, o_repeat, o_release, o_event}, 0);

      // Glitch on ch1 shorter than the minimum debounce
      acc = '0;
      i_sw[1] = 1'b0;
      repeat (6) begin step(); acc |= o_level | o_press | o_release; end
      i_sw[1] = 1'b1;
      repeat (30) begin step(); acc |= o_level | o_press | o_release; end
      chk("glitch_ch1", acc[1], 0);

      // Press, long press and auto-repeat on ch0
      i_sw[0] = 1'b0;
      wait_bit(SEL_PRESS, 0, 20, lat);
      chk_range("press_lat", lat, 11, 15);
      chk("press_event", o_event, 3'b001);
      chk("press_level", o_level, 3'b001);
      chk("press_only_ch0", o_press, 3'b001);
      step();
      chk("press_width", {o_press, o_event}, 0);
      chk("press_level_hold", o_level, 3'b001);
      wait_bit(SEL_LONG, 0, 30, lat);
      chk("long_after_press", lat + 1, 20);
      chk("long_with_repeat", o_repeat[0], 1);
      chk("long_event", o_event[0], 1);
      wait_bit(SEL_REP, 0, 12, lat);
      chk("rep_period1", lat, 8);
      chk("rep1_event", o_event[0], 1);
      chk("rep1_no_long", o_long[0], 0);
      wait_bit(SEL_REP, 0, 12, lat);
      chk("rep_period2", lat, 8);
      repeat (20) step();

      // Release after the long hold
      i_sw[0] = 1'b1;
      wait_bit(SEL_REL, 0, 20, lat);
      chk_range("rel_lat", lat, 11, 15);
      chk("rel_level", o_level[0], 0);
      acc = '0;
      repeat (20) begin step(); acc |= o_repeat | o_release; end
      chk("no_rep_after_rel", acc[0], 0);

      // Bouncy release: one release, no extra press, level held until then
      i_sw[0] = 1'b0;
      wait_bit(SEL_PRESS, 0, 20, lat);
      chk_range("press2_lat", lat, 11, 15);
      np = 0; nr = 0; early = 0; seen_rel = 0;
      for (int k = 0; k < 48; k++) begin
         i_sw[0] = (k < 5) ? 1'b1 : (k < 8) ? 1'b0 : 1'b1;
         step();
         np += int'(o_press[0]);
         if (o_release[0]) begin nr++; seen_rel = 1; end
         if (!seen_rel && !o_level[0]) early++;
      end
      chk("bounce_press", np, 0);
      chk("bounce_release", nr, 1);
      chk("bounce_level_early_drop", early, 0);

      // Reset in the middle of a repeat on ch2
      i_sw[2] = 1'b0;
      wait_bit(SEL_LONG, 2, 45, lat);
      chk_range("ch2_long_lat", lat, 29, 35);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {o_level, o_press, o_long, o_repeat, o_release, o_event}, 0);
      step();
      step();
      rst_n = 1'b1;
      wait_bit(SEL_PRESS, 2, 20, lat);
      chk("press_after_reset", lat, 12);
      chk("level_after_reset", o_level, 3'b100);
      i_sw = '1;
      repeat (30) step();

      // Table-driven press lengths
      for (int t = 0; t < 6; t++) begin
         for (int c = 0; c < N_SW; c++) begin cp[c] = 0; cl[c] = 0; crp[c] = 0; cr[c] = 0; end
         i_sw = ~tbl[t].mask;
         repeat (tbl[t].low) step_count();
         i_sw = '1;
         repeat (40) step_count();
         for (int c = 0; c < N_SW; c++) begin
            if (tbl[t].mask[c]) begin
               chk($sformatf("tbl%0d_press_ch%0d", t, c), cp[c], tbl[t].exp_press);
               chk($sformatf("tbl%0d_long_ch%0d", t, c), cl[c], tbl[t].exp_long);
               chk($sformatf("tbl%0d_rel_ch%0d", t, c), cr[c], tbl[t].exp_rel);
               chk_range($sformatf("tbl%0d_rep_ch%0d", t, c), crp[c], tbl[t].exp_rep_min,
                         (tbl[t].exp_rep_min == 0) ? 0 : 99);
            end else begin
               chk($sformatf("tbl%0d_quiet_ch%0d", t, c), cp[c] + cl[c] + cr[c] + crp[c], 0);
            end
         end
      end

      // Random switch activity, with one mid-cycle reset
      for (int c = 0; c < N_SW; c++) dur[c] = $urandom_range(1, 40);
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < N_SW; c++) begin
            dur[c]--;
            if (dur[c] <= 0) begin
               i_sw[c] = ~i_sw[c];
               dur[c]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                     : int'($urandom_range(9, 80));
            end
         end
         if (k == 1500) begin
            #3 rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end
      i_sw = '1;
      repeat (40) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
